// File: rtl/mirror_filter_pipe_if.sv
// Pixel-in, frame-buffer read and pixel-out bundle for mirror_filter_pipe.
// slave is the filter's view; master is the view of whatever drives it.
interface mirror_filter_pipe_if #(
   parameter int ADDR_WIDTH = 15
);
   logic                  pix_valid_in;
   logic                  sof;
   logic [9:0]            x_local;
   logic [9:0]            y_local;
   logic [15:0]           rgb565_in;
   logic [2:0]            mode_req;
   logic [1:0]            src_sel;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic                  read_en;
   logic [15:0]           frame_buffer_data;
   logic                  pix_valid_out;
   logic [15:0]           rgb565_out;
   logic [9:0]            x_out;
   logic [9:0]            y_out;
   logic [2:0]            mode_active;

   modport slave (
      input  pix_valid_in, sof, x_local, y_local, rgb565_in, mode_req, src_sel,
             frame_buffer_data,
      output read_addr, read_en, pix_valid_out, rgb565_out, x_out, y_out,
             mode_active
   );

   modport master (
      output pix_valid_in, sof, x_local, y_local, rgb565_in, mode_req, src_sel,
             frame_buffer_data,
      input  read_addr, read_en, pix_valid_out, rgb565_out, x_out, y_out,
             mode_active
   );
endinterface

// File: rtl/mirror_filter_pipe.sv
// Mirror/symmetry filter: remaps pixel coordinates to a frame-buffer source,
// issues a registered read, and returns the fetched word after 1+RD_LATENCY cycles.
module mirror_filter_pipe #(
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 120,
   parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   mirror_filter_pipe_if.slave pix
);

   localparam int DL = RD_LATENCY;
   localparam logic [9:0]  W_M1 = 10'(IMG_WIDTH - 1);
   localparam logic [9:0]  H_M1 = 10'(IMG_HEIGHT - 1);
   localparam logic [9:0]  HW   = 10'(IMG_WIDTH / 2);
   localparam logic [9:0]  HH   = 10'(IMG_HEIGHT / 2);
   localparam logic [10:0] W_LIM = 11'(IMG_WIDTH);
   localparam logic [10:0] H_LIM = 11'(IMG_HEIGHT);

   logic [2:0] mode_q;
   logic [1:0] src_q;
   logic [2:0] mode_eff;
   logic [1:0] src_eff;
   logic [9:0] sx;
   logic [9:0] sy;
   logic       flip_x;
   logic       flip_y;
   logic       in_range;
   logic       fetch_mode;
   logic       fetch;
   logic [ADDR_WIDTH-1:0] addr_calc;

   logic        v_q [DL];
   logic        f_q [DL];
   logic [15:0] d_q [DL];
   logic [9:0]  x_q [DL];
   logic [9:0]  y_q [DL];

   // A pixel arriving with sof already sees the mode being latched this cycle.
   assign mode_eff = pix.sof ? pix.mode_req : mode_q;
   assign src_eff  = pix.sof ? pix.src_sel  : src_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q <= 3'd0;
         src_q  <= 2'b01;
      end else if (pix.sof) begin
         mode_q <= pix.mode_req;
         src_q  <= pix.src_sel;
      end
   end

   assign pix.mode_active = mode_q;

   always_comb begin
      sx     = pix.x_local;
      sy     = pix.y_local;
      flip_x = src_eff[0] ? (pix.x_local < HW) : (pix.x_local >= HW);
      flip_y = src_eff[1] ? (pix.y_local < HH) : (pix.y_local >= HH);
      case (mode_eff)
         3'd1: begin
            if (flip_x) sx = W_M1 - pix.x_local;
         end
         3'd2: begin
            if (flip_y) sy = H_M1 - pix.y_local;
         end
         3'd3: begin
            if (flip_x) sx = W_M1 - pix.x_local;
            if (flip_y) sy = H_M1 - pix.y_local;
         end
         3'd4: begin
            sx = W_M1 - pix.x_local;
            sy = H_M1 - pix.y_local;
         end
         default: ;
      endcase
   end

   assign in_range   = ({1'b0, pix.x_local} < W_LIM) && ({1'b0, pix.y_local} < H_LIM);
   assign fetch_mode = (mode_eff >= 3'd1) && (mode_eff <= 3'd4);
   assign fetch      = pix.pix_valid_in && fetch_mode && in_range;
   // Modular arithmetic: the low ADDR_WIDTH bits equal the truncated full product.
   assign addr_calc  = ADDR_WIDTH'(sy) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(sx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix.read_en   <= 1'b0;
         pix.read_addr <= '0;
      end else begin
         pix.read_en <= fetch;
         if (fetch) pix.read_addr <= addr_calc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DL; i++) begin
            v_q[i] <= 1'b0;
            f_q[i] <= 1'b0;
            d_q[i] <= '0;
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else begin
         v_q[0] <= pix.pix_valid_in;
         f_q[0] <= fetch;
         d_q[0] <= pix.rgb565_in;
         x_q[0] <= pix.x_local;
         y_q[0] <= pix.y_local;
         for (int i = 1; i < DL; i++) begin
            v_q[i] <= v_q[i-1];
            f_q[i] <= f_q[i-1];
            d_q[i] <= d_q[i-1];
            x_q[i] <= x_q[i-1];
            y_q[i] <= y_q[i-1];
         end
      end
   end

   // Final stage of the delay line; data fields hold while no pixel is emitted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix.pix_valid_out <= 1'b0;
         pix.rgb565_out    <= '0;
         pix.x_out         <= '0;
         pix.y_out         <= '0;
      end else begin
         pix.pix_valid_out <= v_q[DL-1];
         if (v_q[DL-1]) begin
            pix.rgb565_out <= f_q[DL-1] ? pix.frame_buffer_data : d_q[DL-1];
            pix.x_out      <= x_q[DL-1];
            pix.y_out      <= y_q[DL-1];
         end
      end
   end

endmodule

// File: tb/tb_mirror_filter_pipe.sv
// Directed bench for mirror_filter_pipe with a 2-cycle frame buffer model.
module tb_mirror_filter_pipe;
   localparam int W  = 160;
   localparam int H  = 120;
   localparam int AW = $clog2(W*H);
   localparam int RL = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mirror_filter_pipe_if #(.ADDR_WIDTH(AW)) dif ();

   mirror_filter_pipe #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .ADDR_WIDTH(AW),
      .RD_LATENCY(RL)
   ) u_dut (
      .clk  (clk),
      .reset(rst_n),
      .pix  (dif)
   );

   function automatic logic [15:0] fb_mem(input int a);
      if (a == 3189) return 16'hF800;
      return 16'(a) ^ 16'h5A5A;
   endfunction

   // Frame buffer: data for an address is presented RL-1 cycles after read_addr updates.
   logic [AW-1:0] addr_d1;
   always @(posedge clk) addr_d1 <= dif.read_addr;
   assign dif.frame_buffer_data = fb_mem(int'(addr_d1));

   logic [35:0]   got_q [$];
   logic [AW-1:0] gaddr_q [$];
   always @(posedge clk) begin
      #1;
      if (dif.pix_valid_out === 1'b1) got_q.push_back({dif.x_out, dif.y_out, dif.rgb565_out});
      if (dif.read_en === 1'b1) gaddr_q.push_back(dif.read_addr);
   end

   function automatic int ref_addr(input int m, input int s, input int x, input int y);
      int sx;
      int sy;
      sx = x;
      sy = y;
      if (m == 4) begin
         sx = W - 1 - x;
         sy = H - 1 - y;
      end else begin
         if (m == 1 || m == 3) begin
            if (s % 2 == 1) begin
               if (x < W/2) sx = W - 1 - x;
            end else begin
               if (x >= W/2) sx = W - 1 - x;
            end
         end
         if (m == 2 || m == 3) begin
            if (s / 2 == 1) begin
               if (y < H/2) sy = H - 1 - y;
            end else begin
               if (y >= H/2) sy = H - 1 - y;
            end
         end
      end
      return sy * W + sx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic px(input logic v, input logic s, input int x, input int y,
                     input logic [15:0] rgb, input logic [2:0] m, input logic [1:0] ss);
      dif.pix_valid_in = v;
      dif.sof          = s;
      dif.x_local      = 10'(x);
      dif.y_local      = 10'(y);
      dif.rgb565_in    = rgb;
      dif.mode_req     = m;
      dif.src_sel      = ss;
   endtask

   task automatic idle();
      dif.pix_valid_in = 1'b0;
      dif.sof          = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [35:0]   exp_q [$];
      logic [AW-1:0] eaddr_q [$];
      int            ra;
      rst_n = 1'b0;
      px(0, 0, 0, 0, 16'h0, 3'd0, 2'b00);
      repeat (2) @(negedge clk);
      chk("rst_pvo",   32'(dif.pix_valid_out), 32'd0);
      chk("rst_ren",   32'(dif.read_en), 32'd0);
      chk("rst_addr",  32'(dif.read_addr), 32'd0);
      chk("rst_rgb",   32'(dif.rgb565_out), 32'd0);
      chk("rst_mode",  32'(dif.mode_active), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // quad mode, source right/top
      px(1, 1, 10, 100, 16'h1111, 3'd3, 2'b01);
      @(negedge clk);
      chk("quad_ren",  32'(dif.read_en), 32'd1);
      chk("quad_addr", 32'(dif.read_addr), 32'd3189);
      chk("quad_mode", 32'(dif.mode_active), 32'd3);
      chk("quad_pvo_early", 32'(dif.pix_valid_out), 32'd0);
      idle();
      @(negedge clk);
      chk("quad_pvo_l2", 32'(dif.pix_valid_out), 32'd0);
      @(negedge clk);
      chk("quad_pvo",  32'(dif.pix_valid_out), 32'd1);
      chk("quad_rgb",  32'(dif.rgb565_out), 32'hF800);
      chk("quad_x",    32'(dif.x_out), 32'd10);
      chk("quad_y",    32'(dif.y_out), 32'd100);
      @(negedge clk);
      chk("quad_pvo_after", 32'(dif.pix_valid_out), 32'd0);
      chk("quad_rgb_hold",  32'(dif.rgb565_out), 32'hF800);

      // horizontal mirror
      px(1, 1, 0, 0, 16'h0, 3'd1, 2'b01);
      @(negedge clk);
      chk("hm_r0_addr", 32'(dif.read_addr), 32'd159);
      chk("hm_r0_ren",  32'(dif.read_en), 32'd1);
      px(1, 0, 159, 0, 16'h0, 3'd1, 2'b01);
      @(negedge clk);
      chk("hm_r159_addr", 32'(dif.read_addr), 32'd159);
      chk("hm_r159_ren",  32'(dif.read_en), 32'd1);
      px(1, 1, 80, 5, 16'h2222, 3'd1, 2'b00);
      @(negedge clk);
      chk("hm_l80_addr", 32'(dif.read_addr), 32'd879);
      idle();
      repeat (2) @(negedge clk);
      chk("hm_l80_pvo", 32'(dif.pix_valid_out), 32'd1);
      chk("hm_l80_rgb", 32'(dif.rgb565_out), 32'(fb_mem(879)));
      chk("hm_l80_x",   32'(dif.x_out), 32'd80);
      chk("hm_l80_y",   32'(dif.y_out), 32'd5);
      @(negedge clk);

      // mode change without sof is ignored until the next sof
      px(1, 1, 10, 100, 16'h3333, 3'd3, 2'b01);
      @(negedge clk);
      chk("mc_addr1", 32'(dif.read_addr), 32'd3189);
      px(1, 0, 10, 100, 16'h4444, 3'd0, 2'b01);
      @(negedge clk);
      chk("mc_ren2",  32'(dif.read_en), 32'd1);
      chk("mc_addr2", 32'(dif.read_addr), 32'd3189);
      chk("mc_mode2", 32'(dif.mode_active), 32'd3);
      px(1, 1, 5, 5, 16'hABCD, 3'd0, 2'b01);
      @(negedge clk);
      chk("mc_ren3",  32'(dif.read_en), 32'd0);
      chk("mc_addr3_hold", 32'(dif.read_addr), 32'd3189);
      chk("mc_mode3", 32'(dif.mode_active), 32'd0);
      chk("mc_out1_pvo", 32'(dif.pix_valid_out), 32'd1);
      chk("mc_out1_rgb", 32'(dif.rgb565_out), 32'hF800);
      idle();
      @(negedge clk);
      chk("mc_out2_rgb", 32'(dif.rgb565_out), 32'hF800);
      chk("mc_out2_pvo", 32'(dif.pix_valid_out), 32'd1);
      @(negedge clk);
      chk("mc_out3_pvo", 32'(dif.pix_valid_out), 32'd1);
      chk("mc_out3_rgb", 32'(dif.rgb565_out), 32'hABCD);
      chk("mc_out3_x",   32'(dif.x_out), 32'd5);
      chk("mc_out3_y",   32'(dif.y_out), 32'd5);
      @(negedge clk);

      // rotate-180 and an out-of-range pixel
      px(1, 1, 0, 0, 16'h5555, 3'd4, 2'b01);
      @(negedge clk);
      chk("rot_addr", 32'(dif.read_addr), 32'd19199);
      chk("rot_ren",  32'(dif.read_en), 32'd1);
      px(1, 0, 170, 5, 16'h07E0, 3'd4, 2'b01);
      @(negedge clk);
      chk("oor_ren",  32'(dif.read_en), 32'd0);
      chk("oor_addr_hold", 32'(dif.read_addr), 32'd19199);
      idle();
      @(negedge clk);
      chk("rot_out_rgb", 32'(dif.rgb565_out), 32'(fb_mem(19199)));
      chk("rot_out_x",   32'(dif.x_out), 32'd0);
      @(negedge clk);
      chk("oor_out_pvo", 32'(dif.pix_valid_out), 32'd1);
      chk("oor_out_rgb", 32'(dif.rgb565_out), 32'h07E0);
      chk("oor_out_x",   32'(dif.x_out), 32'd170);
      chk("oor_out_y",   32'(dif.y_out), 32'd5);
      @(negedge clk);

      // reset with pixels in flight
      px(1, 0, 1, 1, 16'h0101, 3'd4, 2'b01);
      @(negedge clk);
      px(1, 0, 2, 2, 16'h0202, 3'd4, 2'b01);
      @(negedge clk);
      px(1, 0, 3, 3, 16'h0303, 3'd4, 2'b01);
      @(negedge clk);
      idle();
      chk("mid_pvo_before", 32'(dif.pix_valid_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_pvo",  32'(dif.pix_valid_out), 32'd0);
      chk("mid_ren",  32'(dif.read_en), 32'd0);
      chk("mid_addr", 32'(dif.read_addr), 32'd0);
      chk("mid_rgb",  32'(dif.rgb565_out), 32'd0);
      chk("mid_x",    32'(dif.x_out), 32'd0);
      chk("mid_mode", 32'(dif.mode_active), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      repeat (6) @(negedge clk);
      chk("mid_no_stale", 32'(got_q.size()), 32'd0);
      chk("mid_mode_after", 32'(dif.mode_active), 32'd0);

      // streamed pixels with random gaps, vertical mirror from bottom half
      got_q.delete();
      gaddr_q.delete();
      for (int i = 0; i < 320; i++) begin
         px(1, (i == 0), i % W, i / W, 16'(i * 3 + 1), 3'd2, 2'b10);
         ra = ref_addr(2, 2, i % W, i / W);
         eaddr_q.push_back(AW'(ra));
         exp_q.push_back({10'(i % W), 10'(i / W), fb_mem(ra)});
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      idle();
      repeat (8) @(negedge clk);
      chk("stream_out_count",  32'(got_q.size()), 32'(exp_q.size()));
      chk("stream_addr_count", 32'(gaddr_q.size()), 32'(eaddr_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size())   chk("stream_pixel", 32'(got_q[i][35:16]) ^ 32'(got_q[i][15:0]) << 20 | 32'(got_q[i][15:0]),
                                     32'(exp_q[i][35:16]) ^ 32'(exp_q[i][15:0]) << 20 | 32'(exp_q[i][15:0]));
         if (i < gaddr_q.size()) chk("stream_addr", 32'(gaddr_q[i]), 32'(eaddr_q[i]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
